// File: rtl/clock_gen_pkg.sv
// Shared constants and elaboration helpers for the clock generator.
// Divider half-periods and counter widths are computed here.
package clock_gen_pkg;

   localparam int DEF_CLK_HZ      = 5000;
   localparam int DEF_FAST_HZ     = 2500;
   localparam int DEF_SLOW_HZ     = 1;
   localparam int DEF_FAST_FACTOR = 500;

   // A return value of 0 flags an unusable output frequency to the caller.
   function automatic int half_period(input int clk_hz, input int out_hz);
      if (out_hz <= 0) return 0;
      return clk_hz / (2 * out_hz);
   endfunction

   function automatic bit divisible(input int num, input int den);
      return (den > 0) && ((num % den) == 0);
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: 50% square wave plus a rising-edge tick strobe.
// sel_b chooses between two half-periods; the caller clears on every switch.
module clock_div_ch
   import clock_gen_pkg::*;
#(
   parameter int HALF_A = 1,
   parameter int HALF_B = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   input  logic sel_b,
   output logic clk_o,
   output logic tick_o
);

   localparam int W = cnt_width((HALF_A > HALF_B) ? HALF_A : HALF_B);
   localparam logic [W-1:0] LIM_A = W'(HALF_A - 1);
   localparam logic [W-1:0] LIM_B = W'(HALF_B - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] lim;
   logic         clk_q, clk_d;
   logic         tick_q, tick_d;

   always_comb begin
      lim    = sel_b ? LIM_B : LIM_A;
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (en) begin
         if (cnt_q == lim) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            // Tick only on the 0->1 toggle, registered alongside the wave.
            tick_d = ~clk_q;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/clock_gen_multi.sv
// Two-channel clock generator: display-scan clock and timekeeping clock,
// with synchronous clear, run enable and a fast mode for the slow channel.
module clock_gen_multi
   import clock_gen_pkg::*;
#(
   parameter int CLK_HZ      = DEF_CLK_HZ,
   parameter int FAST_HZ     = DEF_FAST_HZ,
   parameter int SLOW_HZ     = DEF_SLOW_HZ,
   parameter int FAST_FACTOR = DEF_FAST_FACTOR
) (
   input  logic Clock_5K,
   input  logic Reset,
   input  logic Enable,
   input  logic Clear,
   input  logic Fast_Mode,
   output logic Clock_Fast,
   output logic Clock_Slow,
   output logic Tick_Fast,
   output logic Tick_Slow
);

   localparam int HALF_FAST   = half_period(CLK_HZ, FAST_HZ);
   localparam int HALF_SLOW   = half_period(CLK_HZ, SLOW_HZ);
   localparam int HALF_SLOW_T = (FAST_FACTOR > 0) ? HALF_SLOW / FAST_FACTOR : 0;

   if (!divisible(CLK_HZ, 2 * FAST_HZ) || HALF_FAST == 0) begin : g_bad_fast
      $fatal(1, "clock_gen_multi: CLK_HZ must be a nonzero multiple of 2*FAST_HZ");
   end
   if (!divisible(CLK_HZ, 2 * SLOW_HZ) || HALF_SLOW == 0) begin : g_bad_slow
      $fatal(1, "clock_gen_multi: CLK_HZ must be a nonzero multiple of 2*SLOW_HZ");
   end
   if (!divisible(HALF_SLOW, FAST_FACTOR) || HALF_SLOW_T == 0) begin : g_bad_factor
      $fatal(1, "clock_gen_multi: HALF_SLOW must be a nonzero multiple of FAST_FACTOR");
   end

   logic fast_mode_q, fast_mode_d;
   logic mode_chg;
   logic slow_clr;

   always_comb begin
      fast_mode_d = Fast_Mode;
      // A mode switch restarts the slow channel so its count never overshoots.
      mode_chg    = (Fast_Mode != fast_mode_q);
      slow_clr    = Clear | mode_chg;
   end

   always_ff @(posedge Clock_5K or negedge Reset) begin
      if (!Reset) fast_mode_q <= 1'b0;
      else        fast_mode_q <= fast_mode_d;
   end

   clock_div_ch #(
      .HALF_A (HALF_FAST),
      .HALF_B (HALF_FAST)
   ) u_fast (
      .clk    (Clock_5K),
      .rst_n  (Reset),
      .en     (Enable),
      .clr    (Clear),
      .sel_b  (1'b0),
      .clk_o  (Clock_Fast),
      .tick_o (Tick_Fast)
   );

   clock_div_ch #(
      .HALF_A (HALF_SLOW),
      .HALF_B (HALF_SLOW_T)
   ) u_slow (
      .clk    (Clock_5K),
      .rst_n  (Reset),
      .en     (Enable),
      .clr    (slow_clr),
      .sel_b  (fast_mode_q),
      .clk_o  (Clock_Slow),
      .tick_o (Tick_Slow)
   );

endmodule
